// File: rtl/read_seq_fsm.sv
// -----------------------------------------------------------------------------
// read_seq_fsm
//
// Batches slave read requests, fetches the matching rdata beats from the
// slave, delivers them to the master under backpressure, then flushes for a
// fixed number of cycles before returning to idle.
//
// Ports
//   clk           sole clock, rising edge
//   rst_in        asynchronous active-high reset
//   slave_req     slave request strobe
//   slave_cmd     0 = read, 1 = write (writes are ignored everywhere)
//   slave_ack     one rdata beat returned by the slave this cycle
//   master_ready  master accepted one delivered beat this cycle
//   pres_state    registered state (IDLE=0 COLLECT=1 FETCH=2 DELIVER=3 FLUSH=4)
//   next_state    combinational next state (IDLE while rst_in is high)
//   st_cnt        registered per-state counter
//   batch_len     registered request count latched when COLLECT closes
//   collect_en, fetch_en, deliver_en, flush_en
//                 one-hot decode of pres_state
//   ovf           one-cycle pulse: a read was dropped because the batch was full
//   done          one-cycle pulse on FLUSH -> IDLE
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for the first read request of a batch
// COLLECT | counting reads until DEPTH or until the idle timer expires
// FETCH   | counting slave_ack beats up to batch_len
// DELIVER | counting master_ready handshakes up to batch_len
// FLUSH   | fixed FLUSH_CYC-cycle drain, then done
// -----------------------------------------------------------------------------
module read_seq_fsm #(
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 8,
    parameter int FLUSH_CYC = 1,
    localparam int MAX_A    = (DEPTH > FLUSH_CYC) ? DEPTH : FLUSH_CYC,
    localparam int MAX_V    = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT,
    localparam int CW_RAW   = $clog2(MAX_V + 1),
    localparam int CW       = (CW_RAW < 3) ? 3 : CW_RAW
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          slave_req,
    input  logic          slave_cmd,
    input  logic          slave_ack,
    input  logic          master_ready,
    output logic [2:0]    pres_state,
    output logic [2:0]    next_state,
    output logic [CW-1:0] st_cnt,
    output logic [CW-1:0] batch_len,
    output logic          collect_en,
    output logic          fetch_en,
    output logic          deliver_en,
    output logic          flush_en,
    output logic          ovf,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_FETCH   = 3'd2,
        ST_DELIVER = 3'd3,
        ST_FLUSH   = 3'd4
    } state_t;

    localparam logic [CW-1:0] ONE_C        = CW'(1);
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [CW-1:0] TIMEOUT_C    = CW'(TIMEOUT);
    localparam logic [CW-1:0] FLUSH_LAST_C = CW'(FLUSH_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] blen_q, blen_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          rd_req;

    assign rd_req = slave_req & ~slave_cmd;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            blen_q  <= '0;
            tmr_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blen_q  <= blen_d;
            tmr_q   <= tmr_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blen_d  = blen_q;
        tmr_d   = '0;
        ovf_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d = ST_COLLECT;
                    cnt_d   = ONE_C;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_COLLECT: begin
                tmr_d = tmr_q;
                // A read landing on a full batch is dropped and flagged,
                // even in the cycle the batch closes.
                if (rd_req && (cnt_q == DEPTH_C)) begin
                    ovf_d = 1'b1;
                end
                // Closing takes priority: a read in the closing cycle with
                // room left is not added to the batch being handed off.
                if ((cnt_q == DEPTH_C) || ((TIMEOUT != 0) && (tmr_q == TIMEOUT_C))) begin
                    state_d = ST_FETCH;
                    blen_d  = cnt_q;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end else if (rd_req) begin
                    cnt_d   = cnt_q + ONE_C;
                    tmr_d   = '0;
                end else if (tmr_q != TIMEOUT_C) begin
                    tmr_d   = tmr_q + ONE_C;
                end
            end
            ST_FETCH: begin
                if (cnt_q == blen_q) begin
                    state_d = ST_DELIVER;
                    cnt_d   = '0;
                end else if (slave_ack) begin
                    cnt_d   = cnt_q + ONE_C;
                end
            end
            ST_DELIVER: begin
                if (cnt_q == blen_q) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (master_ready) begin
                    cnt_d   = cnt_q + ONE_C;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST_C) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    blen_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                blen_d  = '0;
            end
        endcase
    end

    assign pres_state = state_q;
    assign next_state = rst_in ? ST_IDLE : state_d;
    assign st_cnt     = cnt_q;
    assign batch_len  = blen_q;
    assign ovf        = ovf_q;
    assign done       = done_q;
    assign collect_en = (state_q == ST_COLLECT);
    assign fetch_en   = (state_q == ST_FETCH);
    assign deliver_en = (state_q == ST_DELIVER);
    assign flush_en   = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_read_seq_fsm.sv
module tb_read_seq_fsm;

    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 8;
    localparam int FLUSH_CYC = 1;
    localparam int CW        = 4;

    logic          clk = 1'b0;
    logic          rst_in = 1'b0;
    logic          slave_req = 1'b0;
    logic          slave_cmd = 1'b0;
    logic          slave_ack = 1'b0;
    logic          master_ready = 1'b0;
    logic [2:0]    pres_state;
    logic [2:0]    next_state;
    logic [CW-1:0] st_cnt;
    logic [CW-1:0] batch_len;
    logic          collect_en, fetch_en, deliver_en, flush_en;
    logic          ovf, done;

    int n_vec = 0;
    int n_err = 0;

    // behavioural reference: phase 0..4 = idle, collect, fetch, deliver, flush
    int m_state, m_cnt, m_blen, m_tmr;
    bit m_ovf, m_done;
    int exp_ns, obs_ns;

    read_seq_fsm #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst_in(rst_in), .slave_req(slave_req), .slave_cmd(slave_cmd),
        .slave_ack(slave_ack), .master_ready(master_ready),
        .pres_state(pres_state), .next_state(next_state), .st_cnt(st_cnt),
        .batch_len(batch_len), .collect_en(collect_en), .fetch_en(fetch_en),
        .deliver_en(deliver_en), .flush_en(flush_en), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_blen = 0; m_tmr = 0; m_ovf = 0; m_done = 0;
    endtask

    function automatic int predict_ns(input bit rd);
        case (m_state)
            0: return rd ? 1 : 0;
            1: return (m_cnt >= DEPTH || (TIMEOUT != 0 && m_tmr >= TIMEOUT)) ? 2 : 1;
            2: return (m_cnt >= m_blen) ? 3 : 2;
            3: return (m_cnt >= m_blen) ? 4 : 3;
            4: return (m_cnt >= FLUSH_CYC - 1) ? 0 : 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_commit(input bit rd, input bit ack, input bit rdy);
        int ns;
        ns = predict_ns(rd);
        m_ovf = 0;
        m_done = 0;
        if (m_state == 0) begin
            m_cnt = rd ? 1 : 0;
            m_tmr = 0;
        end else if (m_state == 1) begin
            m_ovf = rd && (m_cnt == DEPTH);
            if (ns == 2) begin
                m_blen = m_cnt; m_cnt = 0; m_tmr = 0;
            end else if (rd) begin
                m_cnt = m_cnt + 1; m_tmr = 0;
            end else begin
                m_tmr = (m_tmr + 1 > TIMEOUT) ? TIMEOUT : m_tmr + 1;
            end
        end else if (m_state == 2 || m_state == 3) begin
            if (ns != m_state) m_cnt = 0;
            else m_cnt = m_cnt + ((m_state == 2) ? int'(ack) : int'(rdy));
        end else if (m_state == 4) begin
            if (ns == 0) begin
                m_cnt = 0; m_blen = 0; m_done = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        m_state = ns;
    endtask

    // called at a negedge: drive, sample next_state, clock once, return at next negedge
    task automatic apply(input bit req, input bit cmd, input bit ack, input bit rdy);
        slave_req = req; slave_cmd = cmd; slave_ack = ack; master_ready = rdy;
        #1;
        exp_ns = predict_ns(req && !cmd);
        obs_ns = int'(next_state);
        @(posedge clk);
        model_commit(req && !cmd, ack, rdy);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && m_state != 0; i++) apply(0, 0, 1, 1);
        apply(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_in = 1; slave_req = 1; slave_cmd = 0;
        @(posedge clk); @(negedge clk);
        n_vec++; if (pres_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", pres_state); end
        n_vec++; if (st_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", st_cnt); end
        n_vec++; if (batch_len !== '0) begin n_err++; $display("FAIL reset_blen: got %0d expected 0", batch_len); end
        n_vec++; if (ovf !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got ovf=%0b done=%0b expected 0 0", ovf, done); end
        n_vec++; if (next_state !== 3'd0) begin n_err++; $display("FAIL reset_next: got %0d expected 0", next_state); end
        rst_in = 0; slave_req = 0;
        model_reset();
        apply(0, 0, 0, 0);
    endtask

    task automatic test_full_batch();
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 0, 0);
            n_vec++; if (pres_state !== 3'd1 || int'(st_cnt) !== i + 1) begin
                n_err++; $display("FAIL full_collect%0d: got state=%0d cnt=%0d expected 1 %0d", i, pres_state, st_cnt, i + 1); end
        end
        apply(0, 0, 0, 0);
        n_vec++; if (pres_state !== 3'd2 || batch_len !== 4'd4 || st_cnt !== 4'd0) begin
            n_err++; $display("FAIL full_fetch: got state=%0d blen=%0d cnt=%0d expected 2 4 0", pres_state, batch_len, st_cnt); end
        drain();
    endtask

    task automatic test_partial();
        int n;
        apply(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        n = 0;
        while (pres_state == 3'd1 && n < 30) begin apply(0, 0, 0, 0); n++; end
        // eight idle cycles fill the timer; the ninth sees it expired and closes
        n_vec++; if (n !== TIMEOUT + 1) begin n_err++; $display("FAIL partial_len: got %0d cycles expected %0d", n, TIMEOUT + 1); end
        n_vec++; if (pres_state !== 3'd2 || batch_len !== 4'd2) begin
            n_err++; $display("FAIL partial_fetch: got state=%0d blen=%0d expected 2 2", pres_state, batch_len); end
        drain();
    endtask

    task automatic test_overflow();
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin apply(1, 0, 0, 0); pulses += int'(ovf); end
        for (int i = 0; i < 3; i++) begin apply(0, 0, 0, 0); pulses += int'(ovf); end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL ovf_pulses: got %0d expected 1", pulses); end
        n_vec++; if (batch_len !== 4'd4) begin n_err++; $display("FAIL ovf_blen: got %0d expected 4", batch_len); end
        drain();
    endtask

    task automatic test_handshake();
        int dn = 0;
        for (int i = 0; i < 4; i++) apply(1, 0, 0, 0);
        apply(0, 0, 0, 0);
        apply(1, 0, 0, 0);
        n_vec++; if (pres_state !== 3'd2 || st_cnt !== 4'd0 || ovf !== 1'b0) begin
            n_err++; $display("FAIL fetch_ignore_read: got state=%0d cnt=%0d ovf=%0b expected 2 0 0", pres_state, st_cnt, ovf); end
        for (int i = 0; i < 4; i++) apply(0, 0, 1, 0);
        n_vec++; if (st_cnt !== 4'd4 || fetch_en !== 1'b1) begin
            n_err++; $display("FAIL fetch_acks: got cnt=%0d fetch_en=%0b expected 4 1", st_cnt, fetch_en); end
        apply(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0);
            n_vec++; if (deliver_en !== 1'b1 || st_cnt !== 4'd0) begin
                n_err++; $display("FAIL deliver_hold%0d: got en=%0b cnt=%0d expected 1 0", i, deliver_en, st_cnt); end
        end
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 1);
        n_vec++; if (deliver_en !== 1'b1 || st_cnt !== 4'd4) begin
            n_err++; $display("FAIL deliver_count: got en=%0b cnt=%0d expected 1 4", deliver_en, st_cnt); end
        apply(0, 0, 0, 1);
        n_vec++; if (flush_en !== 1'b1) begin n_err++; $display("FAIL flush_enter: got state=%0d expected 4", pres_state); end
        for (int i = 0; i < 4; i++) begin apply(0, 0, 0, 1); dn += int'(done); end
        n_vec++; if (dn !== 1 || pres_state !== 3'd0 || batch_len !== 4'd0) begin
            n_err++; $display("FAIL done_pulse: got done=%0d state=%0d blen=%0d expected 1 0 0", dn, pres_state, batch_len); end
    endtask

    task automatic test_writes();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin apply(1, 1, 0, 0); if (pres_state !== 3'd0) bad++; end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL writes_ignored: got %0d non-idle cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) apply(1, 0, 0, 0);
        apply(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 1, 0);
        apply(0, 0, 0, 1);
        apply(0, 0, 0, 1);
        n_vec++; if (pres_state !== 3'd3 || st_cnt !== 4'd2) begin
            n_err++; $display("FAIL mid_setup: got state=%0d cnt=%0d expected 3 2", pres_state, st_cnt); end
        #2 rst_in = 1;
        #1;
        n_vec++; if (pres_state !== 3'd0 || st_cnt !== 4'd0 || batch_len !== 4'd0 || next_state !== 3'd0) begin
            n_err++; $display("FAIL mid_reset: got state=%0d cnt=%0d blen=%0d ns=%0d expected 0 0 0 0", pres_state, st_cnt, batch_len, next_state); end
        @(posedge clk); @(negedge clk);
        n_vec++; if (done !== 1'b0 || pres_state !== 3'd0) begin
            n_err++; $display("FAIL mid_no_done: got done=%0b state=%0d expected 0 0", done, pres_state); end
        rst_in = 0;
        model_reset();
        apply(1, 0, 0, 0);
        n_vec++; if (pres_state !== 3'd1 || st_cnt !== 4'd1) begin
            n_err++; $display("FAIL mid_resume: got state=%0d cnt=%0d expected 1 1", pres_state, st_cnt); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_in = 1;
                #1;
                n_vec++; if (pres_state !== 3'd0 || st_cnt !== '0 || batch_len !== '0) begin
                    n_err++; $display("FAIL rnd_reset: got state=%0d cnt=%0d blen=%0d expected 0 0 0", pres_state, st_cnt, batch_len); end
                @(posedge clk); @(negedge clk);
                rst_in = 0;
                model_reset();
            end
            apply($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
            n_vec++; if (obs_ns !== exp_ns) begin n_err++; $display("FAIL rnd_next c%0d: got %0d expected %0d", c, obs_ns, exp_ns); end
            n_vec++; if (int'(pres_state) !== m_state) begin n_err++; $display("FAIL rnd_state c%0d: got %0d expected %0d", c, pres_state, m_state); end
            n_vec++; if (int'(st_cnt) !== m_cnt) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", c, st_cnt, m_cnt); end
            n_vec++; if (int'(batch_len) !== m_blen) begin n_err++; $display("FAIL rnd_blen c%0d: got %0d expected %0d", c, batch_len, m_blen); end
            n_vec++; if (ovf !== m_ovf || done !== m_done) begin
                n_err++; $display("FAIL rnd_pulses c%0d: got ovf=%0b done=%0b expected %0b %0b", c, ovf, done, m_ovf, m_done); end
            n_vec++; if ({collect_en, fetch_en, deliver_en, flush_en} !==
                         {m_state == 1, m_state == 2, m_state == 3, m_state == 4}) begin
                n_err++; $display("FAIL rnd_enables c%0d: got %4b for state %0d", c, {collect_en, fetch_en, deliver_en, flush_en}, m_state); end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_full_batch();
        test_partial();
        test_overflow();
        test_handshake();
        test_writes();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/read_seq_fsm.md
READ_SEQ_FSM -- requirements
Module: read_seq_fsm

Interface
REQ-001 Parameter DEPTH, 4: max read requests per batch, >=1.
REQ-002 Parameter TIMEOUT, 8: consecutive request-free COLLECT cycles that close a partial batch; 0 disables the timeout.
REQ-003 Parameter FLUSH_CYC, 1: FLUSH state duration in cycles, >=1.
REQ-004 Localparam CW: clog2 of (max(DEPTH, FLUSH_CYC, TIMEOUT) + 1), minimum 3.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_in  in  1  asynchronous, active-high reset.
REQ-008 slave_req  in  1  slave request strobe.
REQ-009 slave_cmd  in  1  0 = read, 1 = write; writes are ignored in every state.
REQ-010 slave_ack  in  1  slave returned one rdata beat this cycle.
REQ-011 master_ready  in  1  master accepted one delivered beat this cycle.
REQ-012 pres_state  out  3  registered state: IDLE=0, COLLECT=1, FETCH=2, DELIVER=3, FLUSH=4.
REQ-013 next_state  out  3  combinational next state.
REQ-014 st_cnt  out  CW  registered per-state counter.
REQ-015 batch_len  out  CW  registered request count latched on COLLECT exit.
REQ-016 collect_en, fetch_en, deliver_en, flush_en  out  1 each  combinational one-hot decode of pres_state.
REQ-017 ovf  out  1  registered one-cycle pulse for a read request dropped in a full batch.
REQ-018 done  out  1  registered one-cycle pulse on FLUSH->IDLE.

Function
(A read request is slave_req=1 with slave_cmd=0.)
REQ-019 next_state shall be fully specified for every pres_state; undefined encodings shall go to IDLE.
REQ-020 IDLE: read request -> COLLECT with st_cnt<=1 and idle timer<=0; otherwise stay with st_cnt<=0.
REQ-021 COLLECT, read request with st_cnt<DEPTH: st_cnt+1 and idle timer<=0.
REQ-022 COLLECT, read request with st_cnt==DEPTH: st_cnt held and ovf<=1 next cycle.
REQ-023 COLLECT, no read request: idle timer+1, saturating at TIMEOUT.
REQ-024 COLLECT->FETCH when registered st_cnt==DEPTH, or when TIMEOUT!=0 and TIMEOUT consecutive request-free cycles have elapsed.
REQ-025 On COLLECT->FETCH: batch_len<=st_cnt and st_cnt<=0.
REQ-026 FETCH: st_cnt+1 on slave_ack while st_cnt<batch_len; excess acks ignored.
REQ-027 FETCH->DELIVER when st_cnt==batch_len, with st_cnt<=0.
REQ-028 DELIVER: st_cnt+1 on master_ready while st_cnt<batch_len; master_ready=0 holds st_cnt (backpressure, no timeout).
REQ-029 DELIVER->FLUSH when st_cnt==batch_len, with st_cnt<=0.
REQ-030 FLUSH: st_cnt+1 every cycle.
REQ-031 FLUSH->IDLE when st_cnt==FLUSH_CYC-1, with done<=1 for one cycle, st_cnt<=0 and batch_len<=0.
REQ-032 A read request arriving in FETCH, DELIVER or FLUSH shall be ignored, with no ovf.
REQ-033 Counters shall never wrap; every increment is bounded by its state's exit value.

Reset
REQ-034 rst_in=1 shall immediately force pres_state=IDLE, st_cnt=0, batch_len=0, idle timer=0, ovf=0 and done=0 in any state, including mid-batch.
REQ-035 While rst_in=1, next_state shall be IDLE.
REQ-036 After rst_in deasserts, operation resumes on the first rising edge.
REQ-037 A batch interrupted by reset shall be discarded, with no done pulse.

Verification (DEPTH=4, TIMEOUT=8, FLUSH_CYC=1)
REQ-038 Full batch: reads in cycles 0-3 -> COLLECT in cycle 1; st_cnt=4 in cycle 4; FETCH in cycle 5 with batch_len=4.
REQ-039 Partial batch: reads in cycles 0-1, then none -> FETCH with batch_len=2 after 8 request-free COLLECT cycles.
REQ-040 Overflow: 5 consecutive reads -> ovf pulses once; batch_len=4.
REQ-041 Handshake: 4 acks, then master_ready low 3 cycles then high -> st_cnt holds in DELIVER; FLUSH, then IDLE; done=1 for exactly one cycle.
REQ-042 Writes ignored: slave_req=1 with slave_cmd=1 for 10 cycles in IDLE -> pres_state stays 0.
REQ-043 Reset mid-DELIVER with st_cnt=2 -> same-cycle pres_state=0, st_cnt=0, batch_len=0; no done pulse.
